// File: rtl/light_monitor.sv
// rtl/light_monitor.sv - observer that decodes a traffic-light controller's lamps and countdown and flags anomalies
//
// Purpose:
//   Watches the lamp and seven-segment outputs of a light controller. On every
//   tick strobe it decodes the lamp phase and the two-digit countdown. It tracks
//   how long each phase lasts and checks that the countdown steps down by one
//   within a phase. Undecodable symbols and sequence breaks are reported through
//   sticky flags and a saturating event counter.
//
// Ports:
//   CLOCK_50  in   1  system clock, rising edge
//   SW[0]     in   1  synchronous active-high reset
//   tick      in   1  one-cycle strobe: observed outputs are stable, sample them
//   LEDG_in   in   1  observed green lamp
//   LEDR_in   in  18  observed red (bit 17) and amber (bit 0) lamps
//   HEX1_in   in   8  observed tens digit, active-low segments
//   HEX0_in   in   8  observed ones digit, active-low segments
//   phase     out  2  0=OFF 1=GREEN 2=RED 3=AMBER
//   value     out  7  decoded countdown, tens*10+ones
//   run_len   out  7  ticks in the current phase, including this one (sat. 127)
//   last_len  out  7  final run_len of the previous phase
//   err_sym   out  1  sticky: an undecodable digit or lamp symbol was seen
//   err_seq   out  1  sticky: the countdown failed to step down by one
//   err_cnt   out  8  ticks carrying at least one error, saturating at 255

module light_monitor (
   input  logic        CLOCK_50,
   input  logic [0:0]  SW,
   input  logic        tick,
   input  logic        LEDG_in,
   input  logic [17:0] LEDR_in,
   input  logic [7:0]  HEX1_in,
   input  logic [7:0]  HEX0_in,
   output logic [1:0]  phase,
   output logic [6:0]  value,
   output logic [6:0]  run_len,
   output logic [6:0]  last_len,
   output logic        err_sym,
   output logic        err_seq,
   output logic [7:0]  err_cnt
);

   localparam logic [1:0] PH_OFF   = 2'd0;
   localparam logic [1:0] PH_GREEN = 2'd1;
   localparam logic [1:0] PH_RED   = 2'd2;
   localparam logic [1:0] PH_AMBER = 2'd3;

   localparam logic [17:0] LAMP_RED   = 18'h20000;
   localparam logic [17:0] LAMP_AMBER = 18'h00001;

   localparam logic [6:0] RUN_MAX = 7'd127;
   localparam logic [7:0] CNT_MAX = 8'hFF;

   typedef enum logic {
      SYNC  = 1'b0,
      TRACK = 1'b1
   } state_t;

   state_t state, state_nxt;

   logic       rst;
   logic [1:0] phase_nxt;
   logic [6:0] value_nxt;
   logic [6:0] run_len_nxt;
   logic [6:0] last_len_nxt;
   logic       err_sym_nxt;
   logic       err_seq_nxt;
   logic [7:0] err_cnt_nxt;

   // decoded sample
   logic       tens_ok, ones_ok, lamp_ok;
   logic [3:0] tens, ones;
   logic [1:0] lamp_phase;
   logic [6:0] sample_value;
   logic       sym_bad;
   logic       seq_bad;
   logic       err_event;

   assign rst = SW[0];

   // Active-low seven-segment patterns for digits 0..9 (bit 7 is the dot,
   // which must be off).
   function automatic logic [4:0] seg_decode(input logic [7:0] seg);
      logic [4:0] r;
      case (seg)
         8'hC0:   r = {1'b1, 4'd0};
         8'hF9:   r = {1'b1, 4'd1};
         8'hA4:   r = {1'b1, 4'd2};
         8'hB0:   r = {1'b1, 4'd3};
         8'h99:   r = {1'b1, 4'd4};
         8'h92:   r = {1'b1, 4'd5};
         8'h82:   r = {1'b1, 4'd6};
         8'hF8:   r = {1'b1, 4'd7};
         8'h80:   r = {1'b1, 4'd8};
         8'h90:   r = {1'b1, 4'd9};
         default: r = {1'b0, 4'd0};
      endcase
      return r;
   endfunction

   always_comb begin
      {tens_ok, tens} = seg_decode(HEX1_in);
      {ones_ok, ones} = seg_decode(HEX0_in);
   end

   // tens*10 + ones, built from shifts so no multiplier is needed
   assign sample_value = {tens, 3'b000} + {2'b00, tens, 1'b0} + {3'b000, ones};

   // Exactly one lamp lit, or none; anything else is a broken symbol.
   always_comb begin
      lamp_ok    = 1'b1;
      lamp_phase = PH_OFF;
      if (LEDG_in && (LEDR_in == 18'h0)) begin
         lamp_phase = PH_GREEN;
      end else if (!LEDG_in && (LEDR_in == LAMP_RED)) begin
         lamp_phase = PH_RED;
      end else if (!LEDG_in && (LEDR_in == LAMP_AMBER)) begin
         lamp_phase = PH_AMBER;
      end else if (!LEDG_in && (LEDR_in == 18'h0)) begin
         lamp_phase = PH_OFF;
      end else begin
         lamp_ok = 1'b0;
      end
   end

   assign sym_bad = !(tens_ok && ones_ok && lamp_ok);

   // A value of 0 has no legal successor in the same phase, so the down-wrap
   // is caught explicitly rather than relying on 7-bit wraparound.
   always_comb begin
      seq_bad = 1'b0;
      if (tick && !sym_bad && (state == TRACK) && (lamp_phase == phase)) begin
         seq_bad = (value == 7'd0) || (sample_value != (value - 7'd1));
      end
   end

   assign err_event = tick && (sym_bad || seq_bad);

   // Next-state and next-output logic
   always_comb begin
      state_nxt    = state;
      phase_nxt    = phase;
      value_nxt    = value;
      run_len_nxt  = run_len;
      last_len_nxt = last_len;
      err_sym_nxt  = err_sym;
      err_seq_nxt  = err_seq;
      err_cnt_nxt  = err_cnt;

      if (tick) begin
         if (sym_bad) begin
            // Tracked state is frozen; resynchronise on the next clean tick.
            err_sym_nxt = 1'b1;
            state_nxt   = SYNC;
         end else begin
            case (state)
               SYNC: begin
                  phase_nxt   = lamp_phase;
                  value_nxt   = sample_value;
                  run_len_nxt = 7'd1;
                  state_nxt   = TRACK;
               end
               TRACK: begin
                  value_nxt = sample_value;
                  if (lamp_phase == phase) begin
                     if (seq_bad) begin
                        err_seq_nxt = 1'b1;
                     end
                     if (run_len != RUN_MAX) begin
                        run_len_nxt = run_len + 7'd1;
                     end
                  end else begin
                     phase_nxt    = lamp_phase;
                     last_len_nxt = run_len;
                     run_len_nxt  = 7'd1;
                  end
               end
               default: state_nxt = SYNC;
            endcase
         end

         // One count per erroneous tick, however many faults it carries.
         if (err_event && (err_cnt != CNT_MAX)) begin
            err_cnt_nxt = err_cnt + 8'd1;
         end
      end
   end

   // State register; reset overrides any coincident tick.
   always_ff @(posedge CLOCK_50) begin
      if (rst) begin
         state    <= SYNC;
         phase    <= PH_OFF;
         value    <= 7'd0;
         run_len  <= 7'd0;
         last_len <= 7'd0;
         err_sym  <= 1'b0;
         err_seq  <= 1'b0;
         err_cnt  <= 8'd0;
      end else begin
         state    <= state_nxt;
         phase    <= phase_nxt;
         value    <= value_nxt;
         run_len  <= run_len_nxt;
         last_len <= last_len_nxt;
         err_sym  <= err_sym_nxt;
         err_seq  <= err_seq_nxt;
         err_cnt  <= err_cnt_nxt;
      end
   end

endmodule

// File: tb/tb_light_monitor.sv
// tb/tb_light_monitor.sv - directed self-checking bench for light_monitor

module tb_light_monitor;

   logic        CLOCK_50;
   logic [0:0]  SW;
   logic        tick;
   logic        LEDG_in;
   logic [17:0] LEDR_in;
   logic [7:0]  HEX1_in;
   logic [7:0]  HEX0_in;
   logic [1:0]  phase;
   logic [6:0]  value;
   logic [6:0]  run_len;
   logic [6:0]  last_len;
   logic        err_sym;
   logic        err_seq;
   logic [7:0]  err_cnt;

   int errors = 0;
   int checks = 0;

   light_monitor dut (
      .CLOCK_50 (CLOCK_50),
      .SW       (SW),
      .tick     (tick),
      .LEDG_in  (LEDG_in),
      .LEDR_in  (LEDR_in),
      .HEX1_in  (HEX1_in),
      .HEX0_in  (HEX0_in),
      .phase    (phase),
      .value    (value),
      .run_len  (run_len),
      .last_len (last_len),
      .err_sym  (err_sym),
      .err_seq  (err_seq),
      .err_cnt  (err_cnt)
   );

   initial CLOCK_50 = 1'b0;
   always #5 CLOCK_50 = ~CLOCK_50;

   localparam int GREEN = 1;
   localparam int RED   = 2;
   localparam int AMBER = 3;

   function automatic logic [7:0] seg(input int d);
      case (d)
         0: return 8'hC0;
         1: return 8'hF9;
         2: return 8'hA4;
         3: return 8'hB0;
         4: return 8'h99;
         5: return 8'h92;
         6: return 8'h82;
         7: return 8'hF8;
         8: return 8'h80;
         9: return 8'h90;
         default: return 8'hFF;
      endcase
   endfunction

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag, input int ph, input int v, input int rl,
                            input int ll, input int es, input int eq, input int ec);
      check({tag, ".phase"},    int'(phase),    ph);
      check({tag, ".value"},    int'(value),    v);
      check({tag, ".run_len"},  int'(run_len),  rl);
      check({tag, ".last_len"}, int'(last_len), ll);
      check({tag, ".err_sym"},  int'(err_sym),  es);
      check({tag, ".err_seq"},  int'(err_seq),  eq);
      check({tag, ".err_cnt"},  int'(err_cnt),  ec);
   endtask

   // Present raw inputs with a one-cycle tick; outputs are sampled at the
   // following falling edge, after the rising edge that captured them.
   task automatic raw_tick(input logic g, input logic [17:0] r,
                           input logic [7:0] h1, input logic [7:0] h0);
      @(negedge CLOCK_50);
      LEDG_in = g;
      LEDR_in = r;
      HEX1_in = h1;
      HEX0_in = h0;
      tick    = 1'b1;
      @(negedge CLOCK_50);
      tick    = 1'b0;
   endtask

   task automatic lamp_tick(input int lamp, input int n);
      logic        g;
      logic [17:0] r;
      g = 1'b0;
      r = 18'h0;
      case (lamp)
         GREEN:   g = 1'b1;
         RED:     r = 18'h20000;
         AMBER:   r = 18'h00001;
         default: ;
      endcase
      raw_tick(g, r, seg(n / 10), seg(n % 10));
   endtask

   initial begin
      SW      = 1'b1;
      tick    = 1'b0;
      LEDG_in = 1'b0;
      LEDR_in = 18'h0;
      HEX1_in = 8'hC0;
      HEX0_in = 8'hC0;
      repeat (3) @(negedge CLOCK_50);
      check_all("reset", 0, 0, 0, 0, 0, 0, 0);
      SW = 1'b0;

      // Green countdown 15..0
      for (int n = 15; n >= 0; n--) begin
         lamp_tick(GREEN, n);
         check("green.value", int'(value), n);
         check("green.run_len", int'(run_len), 16 - n);
      end
      check_all("green_end", 1, 0, 16, 0, 0, 0, 0);

      // Outputs hold between ticks
      repeat (4) @(negedge CLOCK_50);
      check_all("hold", 1, 0, 16, 0, 0, 0, 0);

      // Phase change to red
      lamp_tick(RED, 9);
      check_all("red9", 2, 9, 1, 16, 0, 0, 0);
      lamp_tick(RED, 8);
      lamp_tick(RED, 7);
      check_all("red7", 2, 7, 3, 16, 0, 0, 0);

      // Skip a count
      lamp_tick(RED, 5);
      check_all("red5_skip", 2, 5, 4, 16, 0, 1, 1);

      // Broken ones digit: everything held, back to SYNC
      raw_tick(1'b0, 18'h20000, seg(0), 8'hFF);
      check_all("bad_digit", 2, 5, 4, 16, 1, 1, 2);
      // SYNC accepts any value without a sequence check and restarts run_len
      lamp_tick(RED, 9);
      check_all("resync", 2, 9, 1, 16, 1, 1, 2);
      lamp_tick(RED, 8);
      check_all("retrack", 2, 8, 2, 16, 1, 1, 2);

      // Green and amber together is an invalid lamp symbol
      raw_tick(1'b1, 18'h00001, seg(0), seg(7));
      check_all("bad_lamp", 2, 8, 2, 16, 1, 1, 3);

      // Saturate the error counter
      for (int i = 0; i < 300; i++) begin
         raw_tick(1'b0, 18'h20000, 8'h00, 8'hFF);
      end
      check("sat.err_cnt", int'(err_cnt), 255);

      // Reset coinciding with a valid tick: reset wins
      @(negedge CLOCK_50);
      SW      = 1'b1;
      LEDG_in = 1'b1;
      LEDR_in = 18'h0;
      HEX1_in = seg(4);
      HEX0_in = seg(2);
      tick    = 1'b1;
      @(negedge CLOCK_50);
      SW   = 1'b0;
      tick = 1'b0;
      check_all("reset_tick", 0, 0, 0, 0, 0, 0, 0);

      // Fresh sync after reset, then count amber down to a down-wrap
      lamp_tick(AMBER, 3);
      check_all("amber3", 3, 3, 1, 0, 0, 0, 0);
      lamp_tick(AMBER, 2);
      lamp_tick(AMBER, 1);
      lamp_tick(AMBER, 0);
      check_all("amber0", 3, 0, 4, 0, 0, 0, 0);
      lamp_tick(AMBER, 0);
      check_all("wrap", 3, 0, 5, 0, 0, 1, 1);

      // OFF is a legal phase
      lamp_tick(0, 0);
      check_all("off", 0, 0, 1, 5, 0, 1, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/light_monitor.md
LIGHT_MONITOR -- requirements
Module: light_monitor

Interface
REQ-001 The block SHALL have the port CLOCK_50, input, 1 bit: the single system clock; all state updates on its rising edge.
REQ-002 The block SHALL have the port SW, input, 1 bit [0:0]: SW[0] is the reset, synchronous and active-high.
REQ-003 The block SHALL have the port tick, input, 1 bit: one-CLOCK_50-cycle strobe marking that the observed light controller has advanced one step and its outputs are stable.
REQ-004 The block SHALL have the port LEDG_in, input, 1 bit: the observed green lamp.
REQ-005 The block SHALL have the port LEDR_in, input, 18 bits: the observed red and amber lamps; bit 17 is red, bit 0 is amber.
REQ-006 The block SHALL have the ports HEX1_in and HEX0_in, inputs, 8 bits each: the observed active-low seven-segment tens and ones patterns.
REQ-007 The block SHALL have the port phase, output, 2 bits: 0=OFF, 1=GREEN, 2=RED, 3=AMBER.
REQ-008 The block SHALL have the port value, output, 7 bits: the decoded countdown (tens*10+ones).
REQ-009 The block SHALL have the port run_len, output, 7 bits: ticks spent in the current phase, including the current tick.
REQ-010 The block SHALL have the port last_len, output, 7 bits: final run_len of the previous phase.
REQ-011 The block SHALL have the ports err_sym and err_seq, outputs, 1 bit each: sticky flags for an undecodable digit/lamp symbol and a countdown sequence violation.
REQ-012 The block SHALL have the port err_cnt, output, 8 bits: total error events, saturating at 255.

Function
REQ-013 The digit decode SHALL map C0,F9,A4,B0,99,92,82,F8,80,90 to 0..9; any other pattern SHALL be invalid.
REQ-014 The lamp decode SHALL be: LEDG_in=1 with LEDR_in=0 gives GREEN; LEDG_in=0 with LEDR_in=18'h20000 gives RED; LEDG_in=0 with LEDR_in=18'h00001 gives AMBER; all zero gives OFF; any other combination SHALL be invalid.
REQ-015 Inputs SHALL be sampled only on cycles where tick=1; all outputs SHALL update on the following rising edge (latency 1 cycle) and hold between ticks.
REQ-016 The control FSM SHALL have the states SYNC and TRACK; reset enters SYNC.
REQ-017 In SYNC, the first tick with a valid sample SHALL load phase and value, set run_len=1, and go to TRACK; no sequence check SHALL apply on that tick.
REQ-018 In TRACK with the same phase as registered, the new value SHALL be required to equal the old value minus 1; on mismatch, err_seq SHALL be set and the new value accepted.
REQ-019 In TRACK with the same phase as registered, run_len SHALL be incremented, saturating at 127.
REQ-020 In TRACK with a phase change, last_len SHALL receive the old run_len and run_len SHALL be set to 1; any value SHALL be accepted without a sequence check.
REQ-021 A tick with an old value of 0 in the same phase (down-wrap) SHALL be treated as a sequence violation.
REQ-022 A tick with any invalid digit or lamp symbol SHALL set err_sym, SHALL leave phase, value and run_len unchanged, and SHALL return the FSM to SYNC.
REQ-023 err_cnt SHALL increment by 1 per tick carrying at least one error, even when both err_sym and err_seq conditions occur on that tick.
REQ-024 A tick coinciding with SW[0]=1 SHALL be ignored; reset wins.

Reset
REQ-025 Reset SHALL set phase=0, value=0, run_len=0, last_len=0, err_sym=0, err_seq=0, err_cnt=0, and FSM=SYNC.
REQ-026 Reset asserted mid-phase SHALL discard all tracking, and the next valid tick SHALL resynchronise per REQ-017.

Verification
REQ-027 The bench SHALL cover: reset, then GREEN ticks showing 15,14,…,0 -> phase=1, value steps down, run_len=16, no errors.
REQ-028 The bench SHALL cover: GREEN 0 then RED 9 -> phase=2, last_len=16, run_len=1, err_cnt=0.
REQ-029 The bench SHALL cover: RED 7 then RED 5 -> err_seq=1, value=5, err_cnt=1.
REQ-030 The bench SHALL cover: HEX0_in=8'hFF on a tick -> err_sym=1, outputs held, FSM in SYNC; the next valid tick clears nothing but reloads value.
REQ-031 The bench SHALL cover: LEDG_in=1 with LEDR_in=18'h00001 -> err_sym=1, err_cnt incremented once.
REQ-032 The bench SHALL cover: 300 forced error ticks -> err_cnt=255 (saturated); then SW[0]=1 for 1 cycle coinciding with a tick -> all outputs zero.
